// File: rtl/mult_arb_pkg.sv
// Shared encodings and default timing for the shared-multiplier arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  localparam logic OWN0 = 1'b0;
  localparam logic OWN1 = 1'b1;

  localparam int START_HOLD_DEF  = 2;
  localparam int TIMEOUT_CYC_DEF = 31;

  // wide enough for START_HOLD up to 7
  localparam int HOLD_W = 3;

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_pick
  import mult_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      pick = (last_owner == OWN0) ? OWN1 : OWN0;
    end else begin
      pick = req1 ? OWN1 : OWN0;
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Arbiter sharing one sequential 8x8 multiplier between two requesters; states IDLE idle | LOAD start held | WAIT await done edge | DONE result pulse.
// Define MULT_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYC cycles with a one-cycle err pulse.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int START_HOLD  = START_HOLD_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] result,
  output logic        mult_start,
  output logic [7:0]  mult_dataa,
  output logic [7:0]  mult_datab,
  input  logic [15:0] mult_product,
  input  logic        mult_done,
  output logic        busy,
  output logic        owner,
  output logic        err
);

  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(START_HOLD - 1);

  if (START_HOLD < 1 || START_HOLD > 7 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("mult_share_arb: START_HOLD must be 1..7 and TIMEOUT_CYC at least 1");
  end

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              last_owner;
  logic              done_prev;
  logic              done_edge;
  logic              timeout;
  logic              pick_valid;
  logic              pick;
  logic              grant;
  logic              gnt0_nxt;
  logic              gnt1_nxt;
  logic              rvalid0_nxt;
  logic              rvalid1_nxt;
  logic              start_nxt;
  logic              busy_nxt;

  rr_pick u_rr_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .pick       (pick)
  );

  assign grant = (state == ST_IDLE) && pick_valid;
  // only a fresh rising edge counts, so a done level left from the last job is ignored
  assign done_edge = (state == ST_WAIT) && mult_done && !done_prev;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      wait_cnt <= '0;
    end else if (state == ST_LOAD && hold_cnt == '0) begin
      wait_cnt <= WAIT_W'(TIMEOUT_CYC - 1);
    end else if (state == ST_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

  assign timeout = (state == ST_WAIT) && !done_edge && (wait_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_valid) state_nxt = ST_LOAD;
      ST_LOAD: if (hold_cnt == '0) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done_edge) begin
          state_nxt = ST_DONE;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0_nxt    = grant && (pick == OWN0);
    gnt1_nxt    = grant && (pick == OWN1);
    rvalid0_nxt = done_edge && (owner == OWN0);
    rvalid1_nxt = done_edge && (owner == OWN1);
    start_nxt   = (state_nxt == ST_LOAD);
    busy_nxt    = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      mult_start <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      owner      <= OWN0;
      last_owner <= OWN1;
      result     <= '0;
      mult_dataa <= '0;
      mult_datab <= '0;
      hold_cnt   <= '0;
      done_prev  <= 1'b0;
    end else begin
      gnt0       <= gnt0_nxt;
      gnt1       <= gnt1_nxt;
      rvalid0    <= rvalid0_nxt;
      rvalid1    <= rvalid1_nxt;
      mult_start <= start_nxt;
      busy       <= busy_nxt;
      err        <= timeout;
      done_prev  <= mult_done;
      if (grant) begin
        owner      <= pick;
        mult_dataa <= (pick == OWN1) ? a1 : a0;
        mult_datab <= (pick == OWN1) ? b1 : b0;
        hold_cnt   <= HOLD_LD;
      end else if (state == ST_LOAD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (done_edge) begin
        result <= mult_product;
      end
      if (state == ST_DONE || timeout) begin
        last_owner <= owner;
      end
    end
  end

endmodule
